// File: rtl/counter_pkg.sv
// Shared definitions for the counter checker: state encoding and default widths.
package counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned DEFAULT_ERR_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SYNC  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StSync  = ST_SYNC,
    StCheck = ST_CHECK
  } state_e;

endpackage

// File: rtl/counter_checker_if.sv
// Observation bus between the counter stimulus side (master) and the checker (slave).
interface counter_checker_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ERR_W = 8
) ();

  logic [WIDTH-1:0] q;
  logic             cnt_reset;
  logic             sample_en;
  logic             locked;
  logic             mismatch;
  logic [WIDTH-1:0] expected;
  logic [ERR_W-1:0] err_count;
  logic             wrap;

  modport master (
    output q,
    output cnt_reset,
    output sample_en,
    input  locked,
    input  mismatch,
    input  expected,
    input  err_count,
    input  wrap
  );

  modport slave (
    input  q,
    input  cnt_reset,
    input  sample_en,
    output locked,
    output mismatch,
    output expected,
    output err_count,
    output wrap
  );

endinterface

// File: rtl/counter_checker_sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q;

  // Count up on inc_i unless already saturated.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/counter_checker.sv
// Observer for a free-running counter: locks onto the sequence, then flags deviations,
// counts errors and reports correct wrap-arounds.
module counter_checker
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned ERR_W    = DEFAULT_ERR_W,
  parameter int unsigned LOCK_LEN = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  counter_checker_if.slave  bus
);

  // Lock counter only needs to reach LOCK_LEN.
  localparam int unsigned LockW = (LOCK_LEN < 2) ? 1 : $clog2(LOCK_LEN + 1);

  state_e           state_q, state_d;
  logic [LockW-1:0] lock_q, lock_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             mis_q, mis_d;
  logic             wrap_q, wrap_d;
  logic             err_inc;

  logic [WIDTH-1:0] q_inc;
  logic [LockW-1:0] lock_inc;
  logic             match;

  assign q_inc    = bus.q + WIDTH'(1);
  assign lock_inc = lock_q + LockW'(1);
  assign match    = (bus.q == exp_q);

  // Next-state and pulse generation; cnt_reset overrides the state logic.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    exp_d   = exp_q;
    mis_d   = 1'b0;
    wrap_d  = 1'b0;
    err_inc = 1'b0;

    if (bus.cnt_reset) begin
      state_d = StSync;
      lock_d  = '0;
      if (bus.sample_en) begin
        // Counter held in reset must read zero; next value after release is 1.
        exp_d = WIDTH'(1);
        if ((state_q == StCheck) && (bus.q != '0)) begin
          mis_d   = 1'b1;
          err_inc = 1'b1;
        end
      end else begin
        exp_d = '0;
      end
    end else if (bus.sample_en) begin
      unique case (state_q)
        StIdle: begin
          exp_d   = q_inc;
          lock_d  = '0;
          state_d = StSync;
        end
        StSync: begin
          exp_d = q_inc;
          if (match) begin
            lock_d = lock_inc;
            if (lock_inc >= LockW'(LOCK_LEN)) begin
              state_d = StCheck;
            end
          end else begin
            lock_d = '0;
          end
        end
        StCheck: begin
          // Resynchronise to the observed value whether or not it matched.
          exp_d = q_inc;
          if (match) begin
            wrap_d = (bus.q == '0);
          end else begin
            mis_d   = 1'b1;
            err_inc = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          lock_d  = '0;
        end
      endcase
    end
  end

  // State, prediction and pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      lock_q  <= '0;
      exp_q   <= '0;
      mis_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      exp_q   <= exp_d;
      mis_q   <= mis_d;
      wrap_q  <= wrap_d;
    end
  end

  sat_counter #(
    .Width (ERR_W)
  ) u_err_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (err_inc),
    .count_o (bus.err_count)
  );

  assign bus.locked   = (state_q == StCheck);
  assign bus.mismatch = mis_q;
  assign bus.wrap     = wrap_q;
  assign bus.expected = exp_q;

endmodule
